// File: rtl/period_meter.sv
// period_meter: measures period and high time of an async input
// in ref_clk cycles, averaged over 2^AVG_LOG2 periods.
module period_meter #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AVG_LOG2    = 0,
  parameter logic [31:0] TIMEOUT     = 32'd250_000_000
) (
  input  logic             ref_clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             en,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_cycles,
  output logic             valid,
  output logic             timeout
);

  localparam int unsigned AW = WIDTH + AVG_LOG2;
  localparam int unsigned SW = AVG_LOG2 + 1;
  localparam logic [SW-1:0] S_LAST = SW'((1 << AVG_LOG2) - 1);
  localparam logic [WIDTH-1:0] T_LAST = WIDTH'(TIMEOUT - 32'd1);
  localparam logic [WIDTH-1:0] ONES = '1;

  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d_q;
  logic                   s;
  logic                   rise;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hcnt_q, hcnt_d;
  logic [WIDTH-1:0] tcnt_q, tcnt_d;
  logic [AW-1:0]    accp_q, accp_d;
  logic [AW-1:0]    acch_q, acch_d;
  logic [SW-1:0]    scnt_q, scnt_d;
  logic [WIDTH-1:0] per_q, per_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             valid_q, valid_d;
  logic             tmo_q, tmo_d;
  logic [AW-1:0]    sum_p, sum_h;
  logic             tmo_hit;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d_q;

  // Synchronizer chain plus one delay flop for edge detection
  always_ff @(posedge ref_clk) begin
    if (rst) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      s_d_q  <= s;
    end
  end

  // Next-state, counters, accumulators and result update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hcnt_d  = hcnt_q;
    tcnt_d  = tcnt_q;
    accp_d  = accp_q;
    acch_d  = acch_q;
    scnt_d  = scnt_q;
    per_d   = per_q;
    hi_d    = hi_q;
    valid_d = 1'b0;
    tmo_d   = tmo_q;
    sum_p   = accp_q + AW'(cnt_q);
    sum_h   = acch_q + AW'(hcnt_q);
    tmo_hit = (tcnt_q == T_LAST);
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      hcnt_d  = '0;
      tcnt_d  = '0;
      accp_d  = '0;
      acch_d  = '0;
      scnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d   = '0;
          hcnt_d  = '0;
          tcnt_d  = '0;
          accp_d  = '0;
          acch_d  = '0;
          scnt_d  = '0;
          state_d = ARM;
        end
        ARM: begin
          tcnt_d = (tcnt_q == ONES) ? tcnt_q : tcnt_q + 1'b1;
          if (tmo_hit) begin
            tmo_d  = 1'b1;
            tcnt_d = '0;
          end else if (rise) begin
            state_d = RUN;
            cnt_d   = WIDTH'(1);
            hcnt_d  = WIDTH'(1);
            tcnt_d  = '0;
          end
        end
        RUN: begin
          if (tmo_hit) begin
            tmo_d   = 1'b1;
            state_d = ARM;
            cnt_d   = '0;
            hcnt_d  = '0;
            tcnt_d  = '0;
            accp_d  = '0;
            acch_d  = '0;
            scnt_d  = '0;
          end else if (rise) begin
            cnt_d  = WIDTH'(1);
            hcnt_d = WIDTH'(1);
            tcnt_d = '0;
            if (scnt_q == S_LAST) begin
              per_d   = WIDTH'(sum_p >> AVG_LOG2);
              hi_d    = WIDTH'(sum_h >> AVG_LOG2);
              valid_d = 1'b1;
              tmo_d   = 1'b0;
              accp_d  = '0;
              acch_d  = '0;
              scnt_d  = '0;
            end else begin
              accp_d = sum_p;
              acch_d = sum_h;
              scnt_d = scnt_q + 1'b1;
            end
          end else begin
            cnt_d  = (cnt_q == ONES) ? cnt_q : cnt_q + 1'b1;
            tcnt_d = (tcnt_q == ONES) ? tcnt_q : tcnt_q + 1'b1;
            if (s && hcnt_q != ONES) hcnt_d = hcnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge ref_clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hcnt_q  <= '0;
      tcnt_q  <= '0;
      accp_q  <= '0;
      acch_q  <= '0;
      scnt_q  <= '0;
      per_q   <= '0;
      hi_q    <= '0;
      valid_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hcnt_q  <= hcnt_d;
      tcnt_q  <= tcnt_d;
      accp_q  <= accp_d;
      acch_q  <= acch_d;
      scnt_q  <= scnt_d;
      per_q   <= per_d;
      hi_q    <= hi_d;
      valid_q <= valid_d;
      tmo_q   <= tmo_d;
    end
  end

  assign period      = per_q;
  assign high_cycles = hi_q;
  assign valid       = valid_q;
  assign timeout     = tmo_q;

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: directed scenarios on two instances
// (no averaging and 4-period averaging), TIMEOUT=1000.
module tb_period_meter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sig_in = 1'b0;
  logic        en = 1'b0;
  logic [31:0] per0, hi0, per2, hi2;
  logic        valid0, tmo0, valid2, tmo2;

  int errors = 0;
  int checks = 0;
  int cyc_n = 0;
  int rise_cyc = 0;
  int v0_cnt = 0, v0_last = 0, v0_prev = 0;
  int v2_cnt = 0;

  period_meter #(.WIDTH(32), .SYNC_STAGES(2), .AVG_LOG2(0),
                 .TIMEOUT(32'd1000)) dut0 (
    .ref_clk(clk), .rst(rst), .sig_in(sig_in), .en(en),
    .period(per0), .high_cycles(hi0), .valid(valid0), .timeout(tmo0));

  period_meter #(.WIDTH(32), .SYNC_STAGES(2), .AVG_LOG2(2),
                 .TIMEOUT(32'd1000)) dut2 (
    .ref_clk(clk), .rst(rst), .sig_in(sig_in), .en(en),
    .period(per2), .high_cycles(hi2), .valid(valid2), .timeout(tmo2));

  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(negedge clk) begin
    if (valid0) begin
      v0_cnt  = v0_cnt + 1;
      v0_prev = v0_last;
      v0_last = cyc_n;
    end
    if (valid2) v2_cnt = v2_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wave(input int p, input int h, input int n);
    for (int i = 0; i < n; i++) begin
      sig_in = 1'b1;
      rise_cyc = cyc_n;
      repeat (h) tick();
      sig_in = 1'b0;
      repeat (p - h) tick();
    end
  endtask

  task automatic close_rise(input int h);
    sig_in = 1'b1;
    rise_cyc = cyc_n;
    repeat (h) tick();
    sig_in = 1'b0;
    repeat (8) tick();
  endtask

  task automatic restart();
    en = 1'b0;
    repeat (3) tick();
    en = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (per0 !== 32'd0) begin errors++;
      $display("FAIL rst_period0 got %0d exp 0", per0); end
    checks++; if (hi0 !== 32'd0) begin errors++;
      $display("FAIL rst_high0 got %0d exp 0", hi0); end
    checks++; if (valid0 !== 1'b0) begin errors++;
      $display("FAIL rst_valid0 got %b exp 0", valid0); end
    checks++; if (tmo0 !== 1'b0) begin errors++;
      $display("FAIL rst_timeout0 got %b exp 0", tmo0); end
    checks++; if (per2 !== 32'd0) begin errors++;
      $display("FAIL rst_period2 got %0d exp 0", per2); end
    checks++; if (valid2 !== 1'b0) begin errors++;
      $display("FAIL rst_valid2 got %b exp 0", valid2); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int b0, b2;
    restart();
    b0 = v0_cnt;
    b2 = v2_cnt;
    wave(125, 62, 5);
    repeat (4) tick();
    checks++; if (v0_cnt - b0 !== 4) begin errors++;
      $display("FAIL basic_count0 got %0d exp 4", v0_cnt - b0); end
    checks++; if (per0 !== 32'd125) begin errors++;
      $display("FAIL basic_period0 got %0d exp 125", per0); end
    checks++; if (hi0 !== 32'd62) begin errors++;
      $display("FAIL basic_high0 got %0d exp 62", hi0); end
    checks++; if (v0_last - v0_prev !== 125) begin errors++;
      $display("FAIL basic_spacing got %0d exp 125", v0_last - v0_prev); end
    checks++; if (v0_last - rise_cyc !== 3) begin errors++;
      $display("FAIL basic_latency got %0d exp 3", v0_last - rise_cyc); end
    checks++; if (v2_cnt - b2 !== 1) begin errors++;
      $display("FAIL basic_count2 got %0d exp 1", v2_cnt - b2); end
    checks++; if (per2 !== 32'd125) begin errors++;
      $display("FAIL basic_period2 got %0d exp 125", per2); end
    checks++; if (hi2 !== 32'd62) begin errors++;
      $display("FAIL basic_high2 got %0d exp 62", hi2); end
  endtask

  task automatic test_avg();
    int b0, b2;
    restart();
    b0 = v0_cnt;
    b2 = v2_cnt;
    wave(100, 50, 1);
    wave(101, 50, 1);
    wave(102, 50, 1);
    wave(103, 50, 1);
    close_rise(50);
    checks++; if (v2_cnt - b2 !== 1) begin errors++;
      $display("FAIL avg_count2 got %0d exp 1", v2_cnt - b2); end
    checks++; if (per2 !== 32'd101) begin errors++;
      $display("FAIL avg_period2 got %0d exp 101", per2); end
    checks++; if (hi2 !== 32'd50) begin errors++;
      $display("FAIL avg_high2 got %0d exp 50", hi2); end
    checks++; if (v0_cnt - b0 !== 4) begin errors++;
      $display("FAIL avg_count0 got %0d exp 4", v0_cnt - b0); end
    checks++; if (per0 !== 32'd103) begin errors++;
      $display("FAIL avg_period0 got %0d exp 103", per0); end
  endtask

  task automatic test_timeout();
    int b0;
    en = 1'b0;
    repeat (3) tick();
    b0 = v0_cnt;
    en = 1'b1;
    repeat (990) tick();
    checks++; if (tmo0 !== 1'b0) begin errors++;
      $display("FAIL tmo_early got %b exp 0", tmo0); end
    repeat (20) tick();
    checks++; if (tmo0 !== 1'b1) begin errors++;
      $display("FAIL tmo_set got %b exp 1", tmo0); end
    checks++; if (v0_cnt - b0 !== 0) begin errors++;
      $display("FAIL tmo_novalid got %0d exp 0", v0_cnt - b0); end
    checks++; if (per0 !== 32'd103) begin errors++;
      $display("FAIL tmo_hold got %0d exp 103", per0); end
    sig_in = 1'b1;
    repeat (62) tick();
    checks++; if (tmo0 !== 1'b1) begin errors++;
      $display("FAIL tmo_sticky got %b exp 1", tmo0); end
    sig_in = 1'b0;
    repeat (63) tick();
    wave(125, 62, 2);
    close_rise(62);
    checks++; if (tmo0 !== 1'b0) begin errors++;
      $display("FAIL tmo_clear got %b exp 0", tmo0); end
    checks++; if (per0 !== 32'd125) begin errors++;
      $display("FAIL tmo_period got %0d exp 125", per0); end
    checks++; if (v0_cnt - b0 !== 3) begin errors++;
      $display("FAIL tmo_count got %0d exp 3", v0_cnt - b0); end
  endtask

  task automatic test_en_drop();
    int b2;
    restart();
    b2 = v2_cnt;
    wave(125, 62, 3);
    en = 1'b0;
    repeat (10) tick();
    checks++; if (v2_cnt - b2 !== 0) begin errors++;
      $display("FAIL endrop_novalid got %0d exp 0", v2_cnt - b2); end
    checks++; if (per2 !== 32'd101) begin errors++;
      $display("FAIL endrop_hold got %0d exp 101", per2); end
    en = 1'b1;
    repeat (3) tick();
    wave(110, 40, 5);
    close_rise(40);
    checks++; if (v2_cnt - b2 !== 1) begin errors++;
      $display("FAIL endrop_count got %0d exp 1", v2_cnt - b2); end
    checks++; if (per2 !== 32'd110) begin errors++;
      $display("FAIL endrop_period got %0d exp 110", per2); end
    checks++; if (hi2 !== 32'd40) begin errors++;
      $display("FAIL endrop_high got %0d exp 40", hi2); end
  endtask

  task automatic test_min();
    int b0, b2;
    restart();
    b0 = v0_cnt;
    b2 = v2_cnt;
    wave(4, 2, 6);
    close_rise(2);
    checks++; if (v0_cnt - b0 !== 6) begin errors++;
      $display("FAIL min_count0 got %0d exp 6", v0_cnt - b0); end
    checks++; if (per0 !== 32'd4) begin errors++;
      $display("FAIL min_period0 got %0d exp 4", per0); end
    checks++; if (hi0 !== 32'd2) begin errors++;
      $display("FAIL min_high0 got %0d exp 2", hi0); end
    checks++; if (v0_last - v0_prev !== 4) begin errors++;
      $display("FAIL min_spacing got %0d exp 4", v0_last - v0_prev); end
    checks++; if (v2_cnt - b2 !== 1) begin errors++;
      $display("FAIL min_count2 got %0d exp 1", v2_cnt - b2); end
    checks++; if (per2 !== 32'd4) begin errors++;
      $display("FAIL min_period2 got %0d exp 4", per2); end
  endtask

  task automatic test_rst_mid();
    restart();
    wave(125, 62, 2);
    sig_in = 1'b1;
    repeat (10) tick();
    checks++; if (per0 !== 32'd125) begin errors++;
      $display("FAIL rstmid_pre got %0d exp 125", per0); end
    rst = 1'b1;
    tick();
    checks++; if (per0 !== 32'd0) begin errors++;
      $display("FAIL rstmid_period0 got %0d exp 0", per0); end
    checks++; if (hi0 !== 32'd0) begin errors++;
      $display("FAIL rstmid_high0 got %0d exp 0", hi0); end
    checks++; if (valid0 !== 1'b0) begin errors++;
      $display("FAIL rstmid_valid0 got %b exp 0", valid0); end
    checks++; if (per2 !== 32'd0) begin errors++;
      $display("FAIL rstmid_period2 got %0d exp 0", per2); end
    rst = 1'b0;
    sig_in = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_avg();
    test_timeout();
    test_en_drop();
    test_min();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
